// File: rtl/draw_pkg.sv
// draw_pkg: shared state encoding, colour constants and default screen geometry for the draw sequencer
package draw_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PLAY, S_FINAL, S_WIN, S_DONE} state_t;
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_X_MAX = 159;
  localparam int DEF_Y_MAX = 119;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x-then-y raster scan over a rectangle [X0..X_LAST] x [Y0..Y_LAST]
// ports: clk, rst (async), en advances one pixel, clr reloads the origin,
//        x/y current pixel, last high on the final pixel of the rectangle
module raster_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int X0 = 0,
  parameter int Y0 = 0,
  parameter int X_LAST = 159,
  parameter int Y_LAST = 119
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           clr,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  logic x_end, y_end;
  assign x_end = x == X_W'(X_LAST);
  assign y_end = y == Y_W'(Y_LAST);
  assign last = x_end && y_end;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= X_W'(X0);
      y <= Y_W'(Y0);
    end else if (en) begin
      x <= x_end ? X_W'(X0) : x + 1'b1;
      if (x_end) y <= y_end ? Y_W'(Y0) : y + 1'b1;
    end
endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: game draw FSM -- screen clear, per-round player/timer pixels, final clear, winner square
// ports: CLOCK_50/reset (async), start and timer_tick pulses, packed player positions/alive/colours,
//        winner index; registered pixel stream x/y/colour/plot plus running and done status
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int X_MAX = DEF_X_MAX,
  parameter int Y_MAX = DEF_Y_MAX,
  parameter int TIMER_ROW = DEF_Y_MAX,
  parameter int WIN_X = 80,
  parameter int WIN_Y = 60,
  parameter int WIN_SIZE = 4
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             timer_tick,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0] p_pos,
  input  logic [NUM_PLAYERS-1:0]           p_alive,
  input  logic [NUM_PLAYERS*3-1:0]         p_colour,
  input  logic [2:0]                       winner,
  output logic [X_W-1:0]                   x,
  output logic [Y_W-1:0]                   y,
  output logic [2:0]                       colour,
  output logic                             plot,
  output logic                             running,
  output logic                             done
);
  localparam int PW = X_W + Y_W;
  localparam int SW = $clog2(NUM_PLAYERS + 1);
  localparam int NS = 1 << SW;
  // slot index NUM_PLAYERS is the timer cycle that closes every round
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_PLAYERS);
  state_t state_q, state_d;
  logic [SW-1:0] slot_q;
  logic [X_W-1:0] timer_x_q;
  logic [2:0] win_col_q;
  logic [X_W-1:0] px [NS];
  logic [Y_W-1:0] py [NS];
  logic [2:0] pc [NS];
  logic pa [NS];
  logic [2:0] wc [8];
  logic [X_W-1:0] scr_x, win_x;
  logic [Y_W-1:0] scr_y, win_y;
  logic scr_en, scr_last, win_en, win_last, timer_last, round_end;
  // unpack player slices into slot-indexed tables; unused slots read as dead
  for (genvar g = 0; g < NS; g++) begin : g_slot
    if (g < NUM_PLAYERS) begin : g_p
      assign {px[g], py[g]} = p_pos[g*PW +: PW];
      assign pc[g] = p_colour[g*3 +: 3];
      assign pa[g] = p_alive[g];
    end else begin : g_n
      assign px[g] = '0;
      assign py[g] = '0;
      assign pc[g] = BLACK;
      assign pa[g] = 1'b0;
    end
  end
  // winner indices beyond the player count draw white
  for (genvar g = 0; g < 8; g++) begin : g_win
    if (g < NUM_PLAYERS) begin : g_p
      assign wc[g] = p_colour[g*3 +: 3];
    end else begin : g_n
      assign wc[g] = WHITE;
    end
  end
  assign scr_en = state_q == S_CLEAR || state_q == S_FINAL;
  assign win_en = state_q == S_WIN;
  assign timer_last = timer_x_q == X_W'(X_MAX);
  assign round_end = state_q == S_PLAY && slot_q == LAST_SLOT;
  // counters sit at their origin whenever their sweep is idle, so each sweep starts clean
  raster_counter #(
    .X_W(X_W), .Y_W(Y_W), .X0(0), .Y0(0), .X_LAST(X_MAX), .Y_LAST(Y_MAX)
  ) u_scr (
    .clk(CLOCK_50), .rst(reset), .en(scr_en), .clr(!scr_en),
    .x(scr_x), .y(scr_y), .last(scr_last)
  );
  raster_counter #(
    .X_W(X_W), .Y_W(Y_W), .X0(WIN_X), .Y0(WIN_Y),
    .X_LAST(WIN_X + WIN_SIZE - 1), .Y_LAST(WIN_Y + WIN_SIZE - 1)
  ) u_win (
    .clk(CLOCK_50), .rst(reset), .en(win_en), .clr(!win_en),
    .x(win_x), .y(win_y), .last(win_last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_CLEAR : state_q;
      S_CLEAR: state_d = scr_last ? S_PLAY : S_CLEAR;
      S_PLAY: state_d = round_end && (timer_last || p_alive == '0) ? S_FINAL : S_PLAY;
      S_FINAL: state_d = scr_last ? S_WIN : S_FINAL;
      S_WIN: state_d = win_last ? S_DONE : S_WIN;
      default: state_d = S_IDLE;
    endcase
  end
  // pixel outputs lag the state by one cycle; running/done are delayed to stay aligned with them
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      slot_q <= '0;
      timer_x_q <= '0;
      win_col_q <= BLACK;
      x <= '0;
      y <= '0;
      colour <= BLACK;
      plot <= 1'b0;
      running <= 1'b0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= state_q == S_PLAY;
      done <= state_q == S_DONE;
      slot_q <= state_q == S_PLAY && slot_q != LAST_SLOT ? slot_q + 1'b1 : '0;
      if (state_q == S_CLEAR) timer_x_q <= '0;
      else if (state_q == S_PLAY && timer_tick && !timer_last) timer_x_q <= timer_x_q + 1'b1;
      if (state_q == S_FINAL && scr_last) win_col_q <= wc[winner];
      plot <= 1'b0;
      case (state_q)
        S_CLEAR, S_FINAL: begin
          plot <= 1'b1;
          x <= scr_x;
          y <= scr_y;
          colour <= BLACK;
        end
        S_PLAY: begin
          plot <= slot_q == LAST_SLOT ? 1'b1 : pa[slot_q];
          x <= slot_q == LAST_SLOT ? timer_x_q : px[slot_q];
          y <= slot_q == LAST_SLOT ? Y_W'(TIMER_ROW) : py[slot_q];
          colour <= slot_q == LAST_SLOT ? WHITE : pc[slot_q];
        end
        S_WIN: begin
          plot <= 1'b1;
          x <= win_x;
          y <= win_y;
          colour <= win_col_q;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed self-checking bench for draw_sequencer
module tb_draw_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic tick = 1'b0;
  logic [59:0] p_pos;
  logic [3:0] p_alive;
  logic [11:0] p_colour;
  logic [2:0] winner;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, running, done;
  int checks = 0;
  int errors = 0;
  int ox [5];
  int oy [5];
  int oc [5];
  draw_sequencer dut (
    .CLOCK_50(clk), .reset(rst), .start(start), .timer_tick(tick),
    .p_pos(p_pos), .p_alive(p_alive), .p_colour(p_colour), .winner(winner),
    .x(x), .y(y), .colour(colour), .plot(plot), .running(running), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic sweep(output int n, output int fx, output int fy, output int lx, output int ly);
    n = 0;
    fx = x;
    fy = y;
    lx = -1;
    ly = -1;
    while (plot && colour == 3'b000 && n < 20000) begin
      lx = x;
      ly = y;
      n++;
      @(negedge clk);
    end
  endtask
  task automatic round(input int tick_at, input int kill_at, output logic [4:0] pat);
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      pat = {pat[3:0], plot};
      ox[i] = x;
      oy[i] = y;
      oc[i] = colour;
      tick = i == tick_at;
      if (i == kill_at) p_alive = 4'b0000;
      @(negedge clk);
    end
    tick = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, fx, fy, lx, ly, cnt, maxt, bad;
    logic [4:0] pat;
    p_pos = {8'd70, 7'd80, 8'd50, 7'd60, 8'd30, 7'd40, 8'd10, 7'd20};
    p_colour = {3'b011, 3'b100, 3'b010, 3'b001};
    p_alive = 4'b1011;
    winner = 3'd2;
    repeat (2) @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    pulse_start();
    check("clr1_first_plot", plot, 1);
    check("clr1_first_x", x, 0);
    check("clr1_first_y", y, 0);
    sweep(n, fx, fy, lx, ly);
    check("clr1_len", n, 19200);
    check("clr1_last_x", lx, 159);
    check("clr1_last_y", ly, 119);
    check("play_running", running, 1);
    round(-1, -1, pat);
    check("r1_pattern", pat, 5'b11011);
    check("r1_p0_x", ox[0], 10);
    check("r1_p0_y", oy[0], 20);
    check("r1_p0_col", oc[0], 1);
    check("r1_p3_x", ox[3], 70);
    check("r1_p3_y", oy[3], 80);
    check("r1_p3_col", oc[3], 3);
    check("r1_timer_x", ox[4], 0);
    check("r1_timer_y", oy[4], 119);
    check("r1_timer_col", oc[4], 7);
    round(3, -1, pat);
    check("r2_timer_pre", ox[4], 0);
    round(-1, -1, pat);
    check("r3_pattern", pat, 5'b11011);
    check("r3_timer_post", ox[4], 1);
    cnt = 0;
    maxt = 0;
    for (int i = 0; i < 2000 && running; i++) begin
      if (plot && colour == 3'b111 && y == 7'd119 && int'(x) > maxt) maxt = x;
      cnt++;
      tick = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
    check("tmr_saturate", maxt, 159);
    check("tmr_round_whole", cnt % 5, 0);
    check("tmr_left_play", running, 0);
    check("fin1_first_x", x, 0);
    check("fin1_first_y", y, 0);
    sweep(n, fx, fy, lx, ly);
    check("fin1_len", n, 19200);
    check("fin1_last_x", lx, 159);
    check("fin1_last_y", ly, 119);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (!plot || colour != 3'b100 || int'(x) != 80 + i % 4 || int'(y) != 60 + i / 4) bad++;
      @(negedge clk);
    end
    check("win_pixels_bad", bad, 0);
    check("win_after_plot", plot, 0);
    check("win_done", done, 1);
    repeat (3) @(negedge clk);
    check("done_hold", done, 1);
    pulse_start();
    check("restart_plot", plot, 1);
    check("restart_x", x, 0);
    check("restart_done", done, 0);
    winner = 3'd5;
    sweep(n, fx, fy, lx, ly);
    check("clr2_len", n, 19200);
    round(-1, 1, pat);
    check("kill_pattern", pat, 5'b11001);
    check("kill_running", running, 0);
    check("kill_fin_plot", plot, 1);
    check("kill_fin_x", x, 0);
    check("kill_fin_y", y, 0);
    sweep(n, fx, fy, lx, ly);
    check("fin2_len", n, 19200);
    check("win_white_col", colour, 7);
    check("win_white_x", x, 80);
    check("win_white_y", y, 60);
    rst = 1'b1;
    @(negedge clk);
    check("rst_win_plot", plot, 0);
    rst = 1'b0;
    p_alive = 4'b1011;
    winner = 3'd2;
    pulse_start();
    repeat (5000) @(negedge clk);
    check("mid_x", x, 40);
    check("mid_y", y, 31);
    #2 rst = 1'b1;
    #1;
    check("async_plot", plot, 0);
    check("async_x", x, 0);
    check("async_y", y, 0);
    check("async_colour", colour, 0);
    check("async_running", running, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_plot", plot, 0);
    pulse_start();
    check("resweep_plot", plot, 1);
    check("resweep_x", x, 0);
    check("resweep_y", y, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
